saida: RTL
==========

Name: saida

Overview:
- Output-side companion to the switch-input stack: the CPU pushes 32-bit result words, and the user steps through them on board LEDs and 7-segment displays with a push-button.
- Internally a DEPTH-entry FIFO with a button synchroniser/edge detector, an EMPTY/SHOW display FSM, and hex-to-7-segment decoding.
- Sits between the CPU output instruction path and the board I/O pins.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2.
- AW, 4, log2(DEPTH); pointer width.
- SYNC_STAGES, 2, synchroniser flops on switchNext.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- _input  in  32  word written by the CPU.
- write  in  1  push strobe; one word per cycle while high.
- switchNext  in  1  raw push-button, asynchronous to clk; a rising edge advances to the next word.
- switchHalf  in  1  display select: 0 = bits [15:0], 1 = bits [31:16].
- output_  out  16  selected half of the displayed word.
- hex0..hex3  out  7 each  active-low segments (gfedcba); hex0 shows the least-significant nibble of output_.
- full  out  1  FIFO holds DEPTH words.
- empty  out  1  FIFO holds 0 words.
- count  out  AW+1  number of words stored.
- overflow  out  1  sticky: a push was attempted while full.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr, rd_ptr, count and overflow are 0; synchroniser flops are 0; FSM is EMPTY.
  - output_ is 0; hex0..3 are 7'h7F (blank); empty=1; full=0.
- Push:
  - On a rising edge with write=1 and full=0: mem[wr_ptr] <= _input; wr_ptr++ (wraps DEPTH-1 to 0).
  - write=1 with full=1: word is dropped, pointers unchanged, overflow <= 1. Only reset clears overflow.
- Button handling:
  - switchNext passes through SYNC_STAGES flops.
  - next_pulse = sync_out & ~sync_prev. This is exactly one cycle per press, regardless of hold length.
  - Debouncing is external to this block.
- Pop: next_pulse with empty=0 and FSM in SHOW → rd_ptr++ (wraps). next_pulse while empty is ignored.
- Simultaneous push and pop, not empty: both occur and count is unchanged.
- Simultaneous push and pop while empty: push only; pop is ignored.
- Simultaneous push and pop while full: pop and push both occur, because the push is qualified by full from the previous cycle OR by a pop in the same cycle. No overflow is flagged.
- count = number of stored words; full = (count == DEPTH); empty = (count == 0); all registered.
- FSM:
  - EMPTY → SHOW when count becomes nonzero.
  - SHOW → EMPTY when a pop leaves count = 0.
  - SHOW stays SHOW otherwise.
- Display:
  - output_ is registered: switchHalf ? mem[rd_ptr][31:16] : mem[rd_ptr][15:0] in SHOW, 0 in EMPTY.
  - Latency is one cycle after any pointer, FSM or switchHalf change.
  - hex digits are combinational from registered output_; all four are blank in EMPTY.
- Hex encoding (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Reset mid-operation: all stored data is logically discarded; memory contents need no clearing.

Decomposition:
- Package saida_pkg holds:
  - DEPTH/AW defaults;
  - SEG_BLANK = 7'h7F;
  - the hex segment constant table;
  - the FSM state enum {EMPTY, SHOW}.
- One sub-module, hex7seg: 4-bit nibble in plus blank in, 7-bit active-low segments out. It is instantiated four times.

Test Plan:
- Reset, then idle 5 cycles → output_=0, hex*=7F, empty=1, count=0, overflow=0.
- Push 32'h1234_ABCD; one cycle later with switchHalf=0 → output_=16'hABCD, hex3..0=08,03,46,21. Set switchHalf=1 → next cycle output_=16'h1234.
- Push 3 words A, B, C; press switchNext held high for 10 cycles → exactly one pop; display shows B; count=2. Press twice more → EMPTY, output_=0.
- Push 17 words 0..16 → full=1 after the 16th; word 16 dropped; overflow=1. Pop all → sequence 0..15, then empty.
- Fill to full, then assert write and next_pulse in the same cycle → count stays 16; overflow stays 0; the new word appears last.
- Push 5 words, assert reset=0 asynchronously between clock edges → outputs reach reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/saida_pkg.sv
// Shared constants and types for the saida output display block.
package saida_pkg;

  localparam int SAIDA_DEPTH       = 16;
  localparam int SAIDA_AW          = 4;
  localparam int SAIDA_SYNC_STAGES = 2;

  // All segments off (segments are active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low gfedcba patterns for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Display FSM: EMPTY while nothing is stored, SHOW while a word is on display.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    SHOW  = 1'b1
  } state_t;

endpackage

// File: rtl/saida_hex7seg.sv
// One hex digit to active-low 7-segment decoder with a blanking input.
module hex7seg
  import saida_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Table lookup; blank overrides the digit.
  always_comb begin
    o_seg = HEX_SEG[i_nibble];
    if (i_blank) o_seg = SEG_BLANK;
  end

endmodule

// File: rtl/saida.sv
// saida: CPU result FIFO stepped through on LEDs / 7-segment displays by a
// push-button. Words are pushed by the CPU and popped by button presses.
//
// Strobe semantics: write is sampled on every rising edge and pushes one word
// per cycle while high; it is accepted when the FIFO was not full on the
// previous cycle, or when a pop happens in the same cycle. A rejected push
// sets the sticky overflow flag. A pop is one synchronised button edge while
// a word is on display; pops with nothing stored are ignored.
module saida
  import saida_pkg::*;
#(
  parameter int DEPTH       = SAIDA_DEPTH,
  parameter int AW          = SAIDA_AW,
  parameter int SYNC_STAGES = SAIDA_SYNC_STAGES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   _input,
  input  logic          write,
  input  logic          switchNext,
  input  logic          switchHalf,
  output logic [15:0]   output_,
  output logic [6:0]    hex0,
  output logic [6:0]    hex1,
  output logic [6:0]    hex2,
  output logic [6:0]    hex3,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]            r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic                   r_full;
  logic                   r_empty;
  logic                   r_overflow;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_prev;
  state_t                 r_state;
  logic [15:0]            r_output;

  logic                   w_next_pulse;
  logic                   w_do_pop;
  logic                   w_do_push;
  logic [AW:0]            w_count_next;
  state_t                 w_state_next;
  logic                   w_blank;

  // Button synchroniser chain plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync      <= '0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], switchNext};
      r_sync_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Push/pop qualification and next-count / next-state computation.
  always_comb begin
    w_next_pulse = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    w_do_pop     = w_next_pulse & ~r_empty & (r_state == SHOW);
    w_do_push    = write & (~r_full | w_do_pop);
    w_count_next = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
    w_state_next = (w_count_next != '0) ? SHOW : EMPTY;
  end

  // Storage array; not reset, stale contents are unreachable after reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= _input;
  end

  // Pointers, occupancy flags, overflow and FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_state    <= EMPTY;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (write && !w_do_push) r_overflow <= 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == FULL_CNT);
      r_empty <= (w_count_next == '0);
      r_state <= w_state_next;
    end
  end

  // Registered display word: selected half of the head entry, zero when empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_output <= '0;
    end else if (r_state == SHOW) begin
      r_output <= switchHalf ? r_mem[r_rd_ptr][31:16] : r_mem[r_rd_ptr][15:0];
    end else begin
      r_output <= '0;
    end
  end

  assign w_blank  = (r_state == EMPTY);
  assign output_  = r_output;
  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;
  assign overflow = r_overflow;

  hex7seg u_hex0 (.i_nibble(r_output[3:0]),   .i_blank(w_blank), .o_seg(hex0));
  hex7seg u_hex1 (.i_nibble(r_output[7:4]),   .i_blank(w_blank), .o_seg(hex1));
  hex7seg u_hex2 (.i_nibble(r_output[11:8]),  .i_blank(w_blank), .o_seg(hex2));
  hex7seg u_hex3 (.i_nibble(r_output[15:12]), .i_blank(w_blank), .o_seg(hex3));

endmodule
